// File: rtl/store_unit.sv
// store_unit: execute-stage store path. Decodes STR micro-ops onto the
// D-cache (through a small store buffer drained over an en/ack port) or onto
// the GPIO output register, flags stores to unmapped addresses and reports
// buffer occupancy so loads can stall behind outstanding stores.
module store_unit #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DC_WORDS   = 31,
  parameter int unsigned GPIO_ADDR  = 32,
  parameter logic [4:0]  UOP_STR    = 5'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  // store request
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  uop,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  // D-cache write port
  output logic        dc_wr_en,
  output logic [4:0]  dc_wr_addr,
  output logic [31:0] dc_wr_data,
  input  logic        dc_wr_ack,
  // GPIO
  output logic [31:0] gpio_out,
  output logic        gpio_wr_pulse,
  // status
  output logic        bad_addr,
  output logic        pending
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   gpio_q, gpio_d;
  logic          gpio_pulse_q, gpio_pulse_d;
  logic          bad_q, bad_d;

  logic          accept;
  logic          is_str;
  logic          hit_dc;
  logic          hit_gpio;
  logic          push;
  logic          pop;

  // Request acceptance, address decode and buffer bookkeeping.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ready     = (count_q < CW'(FIFO_DEPTH));
    accept       = in_valid && in_ready;
    is_str       = accept && (uop == UOP_STR);
    hit_dc       = (addr < DC_WORDS);
    hit_gpio     = (addr == GPIO_ADDR);
    push         = is_str && hit_dc;
    // Acks are only meaningful while a write is being presented.
    pop          = (state_q == WRITE) && dc_wr_ack;

    head_d       = pop  ? head_q + PW'(1) : head_q;
    tail_d       = push ? tail_q + PW'(1) : tail_q;
    count_d      = count_q + CW'(push) - CW'(pop);

    gpio_d       = (is_str && hit_gpio) ? data : gpio_q;
    gpio_pulse_d = is_str && hit_gpio;
    bad_d        = bad_q || (is_str && !hit_dc && !hit_gpio);
  end

  // Drain FSM: present the buffer head until acked, keep going while entries remain.
  always_comb begin
    state_d  = state_q;
    dc_wr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = WRITE;
      end
      WRITE: begin
        dc_wr_en = 1'b1;
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      gpio_q       <= '0;
      gpio_pulse_q <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      gpio_q       <= gpio_d;
      gpio_pulse_q <= gpio_pulse_d;
      bad_q        <= bad_d;
    end
  end

  // Store buffer storage, written at the tail on push.
  // NOTE: the storage array is deliberately not reset; entries are only read
  // while the FSM is in WRITE, and the outputs are forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{addr: addr[4:0], data: data};
  end

  // Output drive: head entry only while a write is being presented.
  always_comb begin
    dc_wr_addr    = dc_wr_en ? mem_q[head_q].addr : '0;
    dc_wr_data    = dc_wr_en ? mem_q[head_q].data : '0;
    gpio_out      = gpio_q;
    gpio_wr_pulse = gpio_pulse_q;
    bad_addr      = bad_q;
    pending       = (count_q != '0);
  end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed self-checking bench for store_unit. Inputs are
// driven and outputs sampled 1 ns after each rising edge.
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  uop;
  logic [31:0] addr;
  logic [31:0] data;
  logic        dc_wr_en;
  logic [4:0]  dc_wr_addr;
  logic [31:0] dc_wr_data;
  logic        dc_wr_ack;
  logic [31:0] gpio_out;
  logic        gpio_wr_pulse;
  logic        bad_addr;
  logic        pending;

  int checks   = 0;
  int failures = 0;

  store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .uop           (uop),
    .addr          (addr),
    .data          (data),
    .dc_wr_en      (dc_wr_en),
    .dc_wr_addr    (dc_wr_addr),
    .dc_wr_data    (dc_wr_data),
    .dc_wr_ack     (dc_wr_ack),
    .gpio_out      (gpio_out),
    .gpio_wr_pulse (gpio_wr_pulse),
    .bad_addr      (bad_addr),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] u, input logic [31:0] a, input logic [31:0] d);
    in_valid = v;
    uop      = u;
    addr     = a;
    data     = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    dc_wr_ack = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_wr_en",   32'(dc_wr_en),      32'd0);
    check("rst_wr_addr", 32'(dc_wr_addr),    32'd0);
    check("rst_wr_data", dc_wr_data,         32'd0);
    check("rst_gpio",    gpio_out,           32'd0);
    check("rst_pulse",   32'(gpio_wr_pulse), 32'd0);
    check("rst_bad",     32'(bad_addr),      32'd0);
    check("rst_pending", 32'(pending),       32'd0);
    check("rst_ready",   32'(in_ready),      32'd1);

    // Single D-cache store, ack tied high: one-cycle write
    dc_wr_ack = 1'b1;
    drive(1'b1, 5'd11, 32'd5, 32'hDEADBEEF);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    check("s1_wr_en",    32'(dc_wr_en),   32'd1);
    check("s1_wr_addr",  32'(dc_wr_addr), 32'd5);
    check("s1_wr_data",  dc_wr_data,      32'hDEADBEEF);
    check("s1_pending",  32'(pending),    32'd1);
    tick();
    check("s1_wr_en_off",   32'(dc_wr_en), 32'd0);
    check("s1_pending_off", 32'(pending),  32'd0);

    // Back-pressure: three stores with ack low
    dc_wr_ack = 1'b0;
    drive(1'b1, 5'd11, 32'd0, 32'h100);
    tick();
    check("bp_ready_1", 32'(in_ready), 32'd1);
    drive(1'b1, 5'd11, 32'd1, 32'h101);
    tick();
    check("bp_ready_2",  32'(in_ready),   32'd0);
    check("bp_wr_en_2",  32'(dc_wr_en),   32'd1);
    check("bp_addr_2",   32'(dc_wr_addr), 32'd0);
    drive(1'b1, 5'd11, 32'd2, 32'h102);
    tick();
    check("bp_held_ready", 32'(in_ready),   32'd0);
    check("bp_held_addr",  32'(dc_wr_addr), 32'd0);
    check("bp_held_data",  dc_wr_data,      32'h100);
    check("bp_pending",    32'(pending),    32'd1);
    dc_wr_ack = 1'b1;
    tick();
    check("bp_w1_addr",  32'(dc_wr_addr), 32'd1);
    check("bp_w1_data",  dc_wr_data,      32'h101);
    check("bp_w1_ready", 32'(in_ready),   32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    check("bp_w2_en",    32'(dc_wr_en),   32'd1);
    check("bp_w2_addr",  32'(dc_wr_addr), 32'd2);
    check("bp_w2_data",  dc_wr_data,      32'h102);
    tick();
    check("bp_done_en",      32'(dc_wr_en), 32'd0);
    check("bp_done_pending", 32'(pending),  32'd0);
    check("bp_done_ready",   32'(in_ready), 32'd1);

    // GPIO store
    drive(1'b1, 5'd11, 32'd32, 32'h000000A5);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    check("gp_out",     gpio_out,            32'h000000A5);
    check("gp_pulse",   32'(gpio_wr_pulse),  32'd1);
    check("gp_wr_en",   32'(dc_wr_en),       32'd0);
    check("gp_pending", 32'(pending),        32'd0);
    tick();
    check("gp_pulse_off", 32'(gpio_wr_pulse), 32'd0);
    check("gp_out_hold",  gpio_out,           32'h000000A5);
    check("gp_wr_en_2",   32'(dc_wr_en),      32'd0);
    check("gp_bad",       32'(bad_addr),      32'd0);

    // Undefined addresses and a non-store uop
    drive(1'b1, 5'd11, 32'd31, 32'h31);
    tick();
    check("b31_bad",   32'(bad_addr),      32'd1);
    check("b31_wr_en", 32'(dc_wr_en),      32'd0);
    check("b31_pulse", 32'(gpio_wr_pulse), 32'd0);
    check("b31_pend",  32'(pending),       32'd0);
    check("b31_gpio",  gpio_out,           32'h000000A5);
    drive(1'b1, 5'd11, 32'd40, 32'h40);
    tick();
    check("b40_bad",   32'(bad_addr),      32'd1);
    check("b40_wr_en", 32'(dc_wr_en),      32'd0);
    check("b40_pulse", 32'(gpio_wr_pulse), 32'd0);
    drive(1'b1, 5'd10, 32'd5, 32'h55);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    check("ldr_wr_en", 32'(dc_wr_en), 32'd0);
    check("ldr_pend",  32'(pending),  32'd0);
    tick();
    check("ldr_wr_en_2", 32'(dc_wr_en), 32'd0);
    check("bad_sticky",  32'(bad_addr), 32'd1);

    // Reset with two buffered entries
    dc_wr_ack = 1'b0;
    drive(1'b1, 5'd11, 32'd3, 32'h303);
    tick();
    drive(1'b1, 5'd11, 32'd4, 32'h404);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    check("mr_pend",  32'(pending),  32'd1);
    check("mr_ready", 32'(in_ready), 32'd0);
    rst_n     = 1'b0;
    dc_wr_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    check("mr_wr_en",   32'(dc_wr_en),   32'd0);
    check("mr_wr_addr", 32'(dc_wr_addr), 32'd0);
    check("mr_pend_0",  32'(pending),    32'd0);
    check("mr_ready_1", 32'(in_ready),   32'd1);
    check("mr_bad",     32'(bad_addr),   32'd0);
    check("mr_gpio",    gpio_out,        32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_ack_no_write", 32'(dc_wr_en), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
